// File: rtl/serial_sub.sv
// serial_sub: bit-serial a - b - bin subtractor, LSB first, with borrow/overflow/zero flags.
module serial_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] sa, sb, r, rn;
  logic [CW-1:0] cnt;
  logic br, brn, d, am, bm, acc, last;
  always_comb begin
    d = sa[0] ^ sb[0] ^ br;
    brn = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    rn = {d, r[WIDTH-1:1]};
    acc = (state == IDLE || state == DONE) && start;
    last = state == SHIFT && cnt == CW'(WIDTH - 1);
    state_n = acc ? SHIFT : last ? DONE : state == DONE ? IDLE : state;
    busy = state == SHIFT;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sa <= '0;
      sb <= '0;
      r <= '0;
      cnt <= '0;
      br <= 1'b0;
      am <= 1'b0;
      bm <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      ovf <= 1'b0;
      zero <= 1'b0;
    end else begin
      state <= state_n;
      if (acc) begin
        sa <= a;
        sb <= b;
        br <= bin;
        cnt <= '0;
        am <= a[WIDTH-1];
        bm <= b[WIDTH-1];
      end else if (state == SHIFT) begin
        sa <= sa >> 1;
        sb <= sb >> 1;
        br <= brn;
        r <= rn;
        cnt <= cnt + CW'(1);
      end
      // outputs latch only when the final bit has just been produced
      if (last) begin
        diff <= rn;
        bout <= brn;
        zero <= rn == '0;
        ovf <= (am != bm) && (rn[WIDTH-1] != am);
      end
    end
  end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed checks of serial_sub (WIDTH=4) handshake, flags and reset.
module tb_serial_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic bin = 1'b0;
  logic busy, done, bout, ovf, zero;
  logic [3:0] diff;
  int errors = 0;
  int checks = 0;

  serial_sub #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [3:0] ed, input logic eb, input logic eo, input logic ez);
    chk({tag, " diff"}, diff, ed);
    chk({tag, " bout"}, {3'b0, bout}, {3'b0, eb});
    chk({tag, " ovf"}, {3'b0, ovf}, {3'b0, eo});
    chk({tag, " zero"}, {3'b0, zero}, {3'b0, ez});
  endtask

  task automatic run(input string tag, input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                     input logic [3:0] ed, input logic eb, input logic eo, input logic ez);
    start = 1'b1; a = ia; b = ib; bin = ibin;
    @(negedge clk);
    start = 1'b0; a = 4'hx; b = 4'hx; bin = 1'bx;
    for (int i = 0; i < 4; i++) begin
      chk({tag, " busy"}, {3'b0, busy}, 4'd1);
      chk({tag, " done early"}, {3'b0, done}, 4'd0);
      @(negedge clk);
    end
    chk({tag, " done"}, {3'b0, done}, 4'd1);
    chk({tag, " busy at done"}, {3'b0, busy}, 4'd0);
    outs(tag, ed, eb, eo, ez);
    @(negedge clk);
    chk({tag, " done pulse"}, {3'b0, done}, 4'd0);
    outs({tag, " hold"}, ed, eb, eo, ez);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst busy", {3'b0, busy}, 4'd0);
    chk("rst done", {3'b0, done}, 4'd0);
    outs("rst", 4'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    run("basic", 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    run("borrow", 4'b0001, 4'b1111, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
    run("ovf", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0);
    run("zero", 4'b0101, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    // handshake: start mid-SHIFT ignored, then start held through DONE
    start = 1'b1; a = 4'b0110; b = 4'b0001; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'b0000; b = 4'b0001; bin = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 4'b0011; b = 4'b0001; bin = 1'b0;
    @(negedge clk);
    chk("hs done1", {3'b0, done}, 4'd1);
    outs("hs res1", 4'b0101, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("hs b2b busy", {3'b0, busy}, 4'd1);
    chk("hs b2b done", {3'b0, done}, 4'd0);
    chk("hs b2b hold", diff, 4'b0101);
    repeat (3) @(negedge clk);
    chk("hs busy tail", {3'b0, busy}, 4'd1);
    @(negedge clk);
    chk("hs done2", {3'b0, done}, 4'd1);
    outs("hs res2", 4'b0010, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    // reset two cycles into an operation
    start = 1'b1; a = 4'b1111; b = 4'b0001; bin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst busy", {3'b0, busy}, 4'd0);
    chk("mid rst done", {3'b0, done}, 4'd0);
    outs("mid rst", 4'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("mid rst no done", {3'b0, done}, 4'd0);
    end
    run("after rst", 4'b1111, 4'b0001, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial WIDTH-bit subtractor computing diff = a − b − bin, LSB first, one bit per clock, with a start/busy/done handshake. It is the subtract-direction companion to the combinational ripple-carry adder. It serves area-constrained datapaths that trade latency for a single full-subtractor cell. It also produces the borrow-out, signed-overflow and zero flags needed by compare logic downstream.

## Interface
- WIDTH, default 4: operand and result width in bits. Minimum legal value is 2.
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a new operation. Sampled only in IDLE or DONE.
- a, input, WIDTH: minuend. Captured on the accepting edge.
- b, input, WIDTH: subtrahend. Captured on the accepting edge.
- bin, input, 1: borrow-in. Captured on the accepting edge.
- busy, output, 1: high while state is SHIFT.
- done, output, 1: single-cycle pulse when the result becomes valid.
- diff, output, WIDTH: result, a − b − bin mod 2^WIDTH.
- bout, output, 1: unsigned borrow-out. 1 iff a < b + bin.
- ovf, output, 1: two's-complement overflow.
- zero, output, 1: 1 iff diff == 0.

## Operation
- States and transitions:
  - IDLE: start=1 → SHIFT.
  - SHIFT: stays for exactly WIDTH cycles, then → DONE.
  - DONE: start=1 → SHIFT; otherwise → IDLE.
- On accept (IDLE or DONE with start=1):
  - Load shift registers sa←a and sb←b.
  - Borrow register br←bin.
  - Bit counter cnt←0.
- Each SHIFT cycle, using the current LSBs x=sa[0] and y=sb[0]:
  - Difference bit: d = x ^ y ^ br.
  - Next borrow: br ← (~x & y) | (~(x ^ y) & br).
  - Shift sa and sb right by one.
  - Shift d into the MSB of the internal result register.
  - cnt ← cnt + 1.
- Leaving SHIFT (cnt reaches WIDTH−1 and that final bit is processed):
  - diff ← completed result register.
  - bout ← final br.
  - zero ← (result == 0).
  - ovf ← (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]), using the captured a and b.
- Hold rule: diff, bout, ovf and zero update only on entry to DONE, then hold until the next DONE entry or reset.
- start while busy=1 is ignored. The operand inputs are don't-care outside the accepting edge.
- The counter width is clog2(WIDTH)+1 so it never wraps before terminal count.

## Timing
- Reset values, taking effect on the first rising edge with rst=1:
  - State = IDLE.
  - busy=0, done=0.
  - diff=0, bout=0, ovf=0, zero=0.
  - Internal registers cleared.
- rst has priority over start and over any in-flight operation. Reset mid-SHIFT aborts with no done pulse, and the partial result is discarded.
- Latency: start accepted at edge E → busy=1 after E through edge E+WIDTH → done=1 and outputs valid in cycle E+WIDTH+1. For WIDTH=4, done is asserted 5 cycles after the accepting edge.
- done is high for exactly one cycle per completed operation.
- Back-to-back operation: start=1 during the DONE cycle is accepted. busy rises the next cycle and the previous result remains on diff until the new DONE.
- Throughput: one result per WIDTH+1 cycles.

## Test plan
- Basic subtract: a=0101, b=0011, bin=0 → diff=0010, bout=0, ovf=0, zero=0. done pulses exactly 5 cycles after start. busy is high for 4 cycles.
- Unsigned borrow: a=0001, b=1111, bin=0 → diff=0010, bout=1, ovf=0.
- Signed overflow: a=1000, b=0001, bin=0 → diff=0111, bout=0, ovf=1.
- Borrow-in to zero: a=0101, b=0100, bin=1 → diff=0000, zero=1, bout=0, ovf=0.
- Handshake:
  - Pulse start again 2 cycles into SHIFT with different operands → ignored; the original result is delivered.
  - Then hold start=1 through DONE → second operation begins the following cycle with no IDLE gap.
- Reset mid-operation: assert rst 2 cycles after start → next cycle has busy=0, all outputs 0, and no done pulse. A fresh start after rst deasserts then completes correctly.
